// File: rtl/cskipa_pkg.sv
// Shared types and widths for the 12-bit carry-skip adder stream stage.
package cskipa_pkg;

    localparam int ADD_W  = 12;
    localparam int BLK_W  = 4;
    localparam int BLK_N  = ADD_W / BLK_W;

    typedef logic [ADD_W-1:0] add_word_t;

    typedef struct packed {
        add_word_t sum;
        logic      cout;
    } add_res_t;

endpackage

// File: rtl/cskipa_stream_stage_adder.sv
// 12-bit carry-skip adder: 4-bit ripple blocks whose carry bypasses a block
// when every bit in it propagates.
module CSkipA_12bit
    import cskipa_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g;
    logic [ADD_W:0]   c;
    logic [BLK_N:0]   bc;

    assign p = a ^ b;
    assign g = a & b;

    // bc[k] is the carry entering block k; it takes the skip path when the
    // whole block propagates, otherwise the block's own ripple carry.
    always_comb begin
        c     = '0;
        bc    = '0;
        bc[0] = cin;
        for (int blk = 0; blk < BLK_N; blk++) begin
            c[blk*BLK_W] = bc[blk];
            for (int i = 0; i < BLK_W; i++) begin
                c[blk*BLK_W+i+1] = g[blk*BLK_W+i] | (p[blk*BLK_W+i] & c[blk*BLK_W+i]);
            end
            bc[blk+1] = (&p[blk*BLK_W +: BLK_W]) ? bc[blk] : c[(blk+1)*BLK_W];
        end
    end

    assign sum  = p ^ c[ADD_W-1:0];
    assign cout = bc[BLK_N];

endmodule

// File: rtl/cskipa_stream_stage.sv
// Two-register valid/ready stage around the carry-skip adder, with saturating
// counters of accepted results and of accepted results carrying out.
module cskipa_stream_stage
    import cskipa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_sum,
    output logic             out_cout,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] cout_cnt
);

    add_word_t op_a;
    add_word_t op_b;
    logic      a_vld;
    add_res_t  res_q;
    logic      b_vld;
    add_word_t add_sum;
    logic      add_cout;
    logic      b_free;
    logic      move_ab;
    logic      in_xfer;
    logic      out_xfer;

    assign b_free   = !b_vld || out_ready;
    assign in_ready = !a_vld || b_free;
    assign move_ab  = a_vld && b_free;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = b_vld && out_ready;

    CSkipA_12bit u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A new pair may enter in the same cycle the old one moves on to B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            a_vld <= 1'b0;
        end else if (in_xfer) begin
            op_a  <= in_a;
            op_b  <= in_b;
            a_vld <= 1'b1;
        end else if (move_ab) begin
            a_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            b_vld <= 1'b0;
        end else if (move_ab) begin
            res_q <= '{sum: add_sum, cout: add_cout};
            b_vld <= 1'b1;
        end else if (out_ready) begin
            b_vld <= 1'b0;
        end
    end

    assign out_valid = b_vld;
    assign out_sum   = res_q.sum;
    assign out_cout  = res_q.cout;

    // Clear wins over a same-cycle transfer; both counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt  <= '0;
            cout_cnt <= '0;
        end else if (stat_clr) begin
            txn_cnt  <= '0;
            cout_cnt <= '0;
        end else if (out_xfer) begin
            if (txn_cnt != '1)
                txn_cnt <= txn_cnt + 1'b1;
            if (res_q.cout && cout_cnt != '1)
                cout_cnt <= cout_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cskipa_stream_stage.sv
// Directed self-checking bench for cskipa_stream_stage (4-bit counters so
// saturation is reachable).
module tb_cskipa_stream_stage;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_a;
    logic [11:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      out_sum;
    logic             out_cout;
    logic             stat_clr;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] cout_cnt;

    int checks   = 0;
    int failures = 0;

    cskipa_stream_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .stat_clr  (stat_clr),
        .txn_cnt   (txn_cnt),
        .cout_cnt  (cout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [11:0] a,
                                 input logic [11:0] b, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [11:0] s_a   [3] = '{12'h123, 12'h800, 12'h7FF};
    logic [11:0] s_b   [3] = '{12'h456, 12'h800, 12'h000};
    logic [11:0] s_sum [3] = '{12'h579, 12'h000, 12'h7FF};
    logic        s_co  [3] = '{1'b0, 1'b1, 1'b0};
    logic [12:0] sb_q  [$];
    logic [12:0] exp_r;
    int          sent;
    int          recv;
    int          cyc;
    int          exp_co;

    initial begin
        rst = 1'b1; stat_clr = 1'b0;
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum",   out_sum,   0);
        checkOutput("rst_out_cout",  out_cout,  0);
        checkOutput("rst_in_ready",  in_ready,  1);
        checkOutput("rst_txn_cnt",   txn_cnt,   0);
        checkOutput("rst_cout_cnt",  cout_cnt,  0);

        $display("[TB] single pair FFF+001");
        applyStimulus(1'b1, 12'hFFF, 12'h001, 1'b1);
        tick();
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        checkOutput("single_lat1_valid", out_valid, 0);
        tick();
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_sum",   out_sum,   12'h000);
        checkOutput("single_cout",  out_cout,  1);
        tick();
        checkOutput("single_drained", out_valid, 0);
        checkOutput("single_txn",     txn_cnt,   1);
        checkOutput("single_coutcnt", cout_cnt,  1);

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 5; i++) begin
            if (i < 3) applyStimulus(1'b1, s_a[i], s_b[i], 1'b1);
            else       applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
            if (i < 3) checkOutput("stream_in_ready", in_ready, 1);
            if (i >= 2) begin
                checkOutput("stream_valid", out_valid, 1);
                checkOutput("stream_sum",   out_sum,   s_sum[i-2]);
                checkOutput("stream_cout",  out_cout,  s_co[i-2]);
            end
            tick();
        end
        checkOutput("stream_drained", out_valid, 0);
        checkOutput("stream_txn",     txn_cnt,   4);
        checkOutput("stream_coutcnt", cout_cnt,  2);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 12'h0A5, 12'h10F, 1'b0);
        checkOutput("bp_ready0", in_ready, 1);
        tick();
        applyStimulus(1'b1, 12'hF00, 12'h200, 1'b0);
        checkOutput("bp_ready1", in_ready, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'h555, 12'h555, 1'b0);
            checkOutput("bp_full_ready", in_ready, 0);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_sum",   out_sum,   12'h1B4);
            checkOutput("bp_hold_cout",  out_cout,  0);
            tick();
        end
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        checkOutput("bp_recover_ready", in_ready, 1);
        checkOutput("bp_drain0_sum",    out_sum,  12'h1B4);
        tick();
        checkOutput("bp_drain1_valid", out_valid, 1);
        checkOutput("bp_drain1_sum",   out_sum,   12'h100);
        checkOutput("bp_drain1_cout",  out_cout,  1);
        tick();
        checkOutput("bp_drained",  out_valid, 0);
        checkOutput("bp_txn",      txn_cnt,   6);
        checkOutput("bp_coutcnt",  cout_cnt,  3);

        $display("[TB] reset while full");
        applyStimulus(1'b1, 12'h123, 12'h001, 1'b0);
        tick();
        applyStimulus(1'b1, 12'h0FF, 12'h001, 1'b0);
        tick();
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b0);
        checkOutput("full_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        checkOutput("mrst_valid", out_valid, 0);
        checkOutput("mrst_sum",   out_sum,   0);
        checkOutput("mrst_ready", in_ready,  1);
        checkOutput("mrst_txn",   txn_cnt,   0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mrst_no_stale", out_valid, 0);
            tick();
        end

        $display("[TB] counter saturation");
        for (int i = 0; i < 22; i++) begin
            if (i < 20) applyStimulus(1'b1, 12'hFFF, 12'h001, 1'b1);
            else        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
            tick();
        end
        checkOutput("sat_drained", out_valid, 0);
        checkOutput("sat_txn",     txn_cnt,   4'hF);
        checkOutput("sat_coutcnt", cout_cnt,  4'hF);
        applyStimulus(1'b1, 12'hFFF, 12'h002, 1'b1);
        tick();
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        tick();
        stat_clr = 1'b1;
        #1;
        checkOutput("clr_xfer_valid", out_valid, 1);
        tick();
        stat_clr = 1'b0;
        checkOutput("clr_txn",     txn_cnt,  0);
        checkOutput("clr_coutcnt", cout_cnt, 0);
        applyStimulus(1'b1, 12'h800, 12'h800, 1'b1);
        tick();
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        tick(); tick();
        checkOutput("post_clr_txn",     txn_cnt,  1);
        checkOutput("post_clr_coutcnt", cout_cnt, 1);

        $display("[TB] random stream");
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        sent = 0; recv = 0; cyc = 0; exp_co = 0;
        while (recv < 12 && cyc < 400) begin
            applyStimulus((sent < 12) ? 1'($urandom_range(0, 1)) : 1'b0,
                          12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("rnd_unexpected_result", out_valid, 0);
                end else begin
                    exp_r = sb_q.pop_front();
                    checkOutput("rnd_sum",  out_sum,  exp_r[11:0]);
                    checkOutput("rnd_cout", out_cout, exp_r[12]);
                    if (exp_r[12]) exp_co++;
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({1'b0, in_a} + {1'b0, in_b});
                sent++;
            end
            tick();
            cyc++;
        end
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b1);
        checkOutput("rnd_recv_count", recv, 12);
        checkOutput("rnd_sb_empty",   sb_q.size(), 0);
        checkOutput("rnd_txn",        txn_cnt,  recv);
        checkOutput("rnd_coutcnt",    cout_cnt, exp_co);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
